// File: rtl/timer_pkg.sv
// Shared constants and types for the millisecond timer.
// Holds the clock-to-millisecond divide computation, the LFSR seed and
// tap mask used by the optional random start delay, and the direction type.
package timer_pkg;

    // 16-bit Fibonacci LFSR: taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Counting direction as seen by the value counter
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Number of system clocks in one millisecond
    function automatic int unsigned calc_clks_per_ms(input int unsigned clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    // One Fibonacci step: shift left, feed back the XOR of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divide-by-CLKS_PER_MS prescaler producing the registered 1 ms tick.
// 'wrap' is the combinational "tick happens on this edge" strobe so the
// owner can update its count on the same edge the registered tick rises.
// The partial millisecond is held while enable is low.
module ms_prescaler #(
    parameter int CLKS_PER_MS = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic ms_tick,
    output logic wrap
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;
    logic          tick_reg;
    logic          tick_next;

    assign wrap    = enable && !clear && (cnt_reg == LAST);
    assign ms_tick = tick_reg;

    // Next-state: clear wins, then count while enabled, otherwise hold
    always_comb begin
        cnt_next  = cnt_reg;
        tick_next = 1'b0;
        if (clear) begin
            cnt_next = '0;
        end else if (enable) begin
            if (cnt_reg == LAST) begin
                cnt_next  = '0;
                tick_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Prescaler count and tick register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            tick_reg <= tick_next;
        end
    end

endmodule

// File: rtl/ms_timer.sv
// Millisecond up/down timer driven by the reaction-time control FSM.
// Counts up (saturating at MAX_MS, flagging a sticky overflow) or down
// (holding at zero) on each 1 ms tick from the prescaler.
// Build option TIMER_RANDOM_DELAY_EN: a clear with up=0 loads a
// pseudo-random delay {1'b1, lfsr[W-2:0]} instead of zero.
module ms_timer
    import timer_pkg::*;
#(
    parameter  int MAX_MS      = 2047,
    parameter  int CLK_FREQ_HZ = 50_000_000,
    localparam int W           = $clog2(MAX_MS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reset,
    input  logic         up,
    input  logic         enable,
    output logic [W-1:0] timer_value,
    output logic         ms_tick,
    output logic         at_limit,
    output logic         overflow
);

    localparam int unsigned   CLKS_PER_MS = calc_clks_per_ms(CLK_FREQ_HZ);
    localparam logic [W-1:0]  MAX_VAL     = W'(MAX_MS);

    dir_e         dir;
    logic         tick_now;
    logic [W-1:0] load_value;
    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;
    logic         overflow_reg;
    logic         overflow_next;

    assign dir = up ? DIR_UP : DIR_DOWN;

    ms_prescaler #(
        .CLKS_PER_MS (int'(CLKS_PER_MS))
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (reset),
        .enable  (enable),
        .ms_tick (ms_tick),
        .wrap    (tick_now)
    );

`ifdef TIMER_RANDOM_DELAY_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_unused;

    // Free-running LFSR; keeps stepping through clears so loads vary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    // Forced MSB makes the delay non-zero and at least half full scale
    assign load_value  = (dir == DIR_DOWN) ? {1'b1, lfsr_reg[W-2:0]} : '0;
    assign lfsr_unused = ^lfsr_reg[15:W-1];
`else
    assign load_value = '0;
`endif

    // Value/overflow next-state: clear first, then the tick update
    always_comb begin
        value_next    = value_reg;
        overflow_next = overflow_reg;
        if (reset) begin
            value_next    = load_value;
            overflow_next = 1'b0;
        end else if (tick_now) begin
            if (dir == DIR_UP) begin
                if (value_reg == MAX_VAL) begin
                    overflow_next = 1'b1;
                end else begin
                    value_next = value_reg + 1'b1;
                end
            end else if (value_reg != '0) begin
                value_next = value_reg - 1'b1;
            end
        end
    end

    // Count value and sticky overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            value_reg    <= value_next;
            overflow_reg <= overflow_next;
        end
    end

    assign timer_value = value_reg;
    assign overflow    = overflow_reg;
    assign at_limit    = (up && (value_reg == MAX_VAL)) || (!up && (value_reg == '0));

endmodule

// File: tb/tb_ms_timer.sv
// Self-checking bench for ms_timer with CLKS_PER_MS=10, MAX_MS=15.
module tb_ms_timer;

    localparam int MAX_MS      = 15;
    localparam int CLK_FREQ_HZ = 10_000;
    localparam int W           = 4;
    localparam int CPM         = 10;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         reset  = 1'b0;
    logic         up     = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] timer_value;
    logic         ms_tick;
    logic         at_limit;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // reference state: elapsed enabled cycles within the current ms, count, flags
    int m_value = 0;
    int m_phase = 0;
    int m_tick  = 0;
    int m_ovf   = 0;

    ms_timer #(
        .MAX_MS      (MAX_MS),
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reset       (reset),
        .up          (up),
        .enable      (enable),
        .timer_value (timer_value),
        .ms_tick     (ms_tick),
        .at_limit    (at_limit),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_clear_all();
        m_value = 0;
        m_phase = 0;
        m_tick  = 0;
        m_ovf   = 0;
    endtask

    // One clock: drive inputs on the falling edge, update model, check after rise
    task automatic step(input logic r, input logic u, input logic e);
        @(negedge clk);
        reset  = r;
        up     = u;
        enable = e;
        @(posedge clk);
        #1;
        m_tick = 0;
        if (r) begin
            m_phase = 0;
            m_ovf   = 0;
            m_value = 0;
`ifdef TIMER_RANDOM_DELAY_EN
            if (!u) begin
                check("rand_load_range", (timer_value >= 8) ? 1 : 0, 1);
                m_value = int'(timer_value);
            end
`endif
        end else if (e) begin
            m_phase++;
            if (m_phase == CPM) begin
                m_phase = 0;
                m_tick  = 1;
                if (u) begin
                    if (m_value == MAX_MS) m_ovf = 1;
                    else m_value = m_value + 1;
                end else if (m_value > 0) begin
                    m_value = m_value - 1;
                end
            end
        end
        check("value", int'(timer_value), m_value);
        check("ms_tick", int'(ms_tick), m_tick);
        check("overflow", int'(overflow), m_ovf);
        check("at_limit", int'(at_limit),
              ((u && m_value == MAX_MS) || (!u && m_value == 0)) ? 1 : 0);
    endtask

    // Drop rst_n between clock edges and confirm the outputs clear at once
    task automatic async_reset_check();
        #1 rst_n = 1'b0;
        #1;
        check("async_value", int'(timer_value), 0);
        check("async_tick", int'(ms_tick), 0);
        check("async_ovf", int'(overflow), 0);
        model_clear_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : main
        int n;
        int v1;
        int v2;
        logic r_rand;
        logic u_rand;
        logic e_rand;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", int'(timer_value), 0);
        check("rst_tick", int'(ms_tick), 0);
        check("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;

        // 1: up-count from release, ticks every 10 cycles
        for (int i = 1; i <= 50; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 10) check("t1_value_c10", int'(timer_value), 1);
            if (i == 50) check("t1_value_c50", int'(timer_value), 5);
        end
        $display("T1 up-count: value=%0d", timer_value);

        // 2: saturation and sticky overflow, then clear
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 170; i++) step(1'b0, 1'b1, 1'b1);
        check("t2_sat_value", int'(timer_value), 15);
        check("t2_ovf", int'(overflow), 1);
        step(1'b1, 1'b1, 1'b0);
        check("t2_clr_value", int'(timer_value), 0);
        check("t2_clr_ovf", int'(overflow), 0);
        $display("T2 saturate/clear done");

        // 3: up to 3, then down to 0 and hold
        for (int i = 1; i <= 30; i++) step(1'b0, 1'b1, 1'b1);
        check("t3_up3", int'(timer_value), 3);
        for (int i = 1; i <= 60; i++) step(1'b0, 1'b0, 1'b1);
        check("t3_down_value", int'(timer_value), 0);
        check("t3_at_limit", int'(at_limit), 1);
        check("t3_ovf", int'(overflow), 0);
        $display("T3 down-count done");

        // 4: pause at prescaler 6, resume -> tick 4 enabled cycles later
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 100; i++) step(1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n++;
            if (ms_tick) break;
        end
        check("t4_resume_latency", n, 4);
        $display("T4 pause/resume latency=%0d", n);

        // 5: clear overrides enable at value 9; then async reset mid-count
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 90; i++) step(1'b0, 1'b1, 1'b1);
        check("t5_value9", int'(timer_value), 9);
        step(1'b1, 1'b1, 1'b1);
        check("t5_clr_value", int'(timer_value), 0);
        check("t5_clr_tick", int'(ms_tick), 0);
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, 1'b1);
        check("t5_first_tick", int'(ms_tick), 1);
        for (int i = 1; i <= 160; i++) step(1'b0, 1'b1, 1'b1);
        check("t5_pre_async_ovf", int'(overflow), 1);
        async_reset_check();
        $display("T5 clear/async reset done");

        // 6: load with up=0 twice, 37 cycles apart
        step(1'b1, 1'b0, 1'b0);
        v1 = int'(timer_value);
        for (int i = 1; i <= 36; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        v2 = int'(timer_value);
`ifdef TIMER_RANDOM_DELAY_EN
        check("t6_loads_differ", (v1 != v2) ? 1 : 0, 1);
        for (int i = 1; i <= v2 * CPM; i++) step(1'b0, 1'b0, 1'b1);
        check("t6_countdown_zero", int'(timer_value), 0);
`else
        check("t6_load1_zero", v1, 0);
        check("t6_load2_zero", v2, 0);
`endif
        $display("T6 loads: %0d %0d", v1, v2);

        // random stimulus against the model
        u_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r_rand = ($urandom_range(0, 49) == 0);
            e_rand = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) u_rand = ~u_rand;
            step(r_rand, u_rand, e_rand);
        end
        $display("Random phase done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
